// File: rtl/l1_dcache_pkg.sv
// Shared types and constants for the L1 data cache: FSM encoding, line record
// and the store byte-merge helper.
package l1_pkg;

  localparam int LINE_BITS     = 512;
  localparam int WORD_BITS     = 64;
  localparam int WORD_LSB      = 3;
  localparam int WORD_SEL_BITS = 3;
  localparam int MAX_TAG_SIZE  = 58;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOOKUP    = 3'd1;
  localparam state_t ST_FILL      = 3'd2;
  localparam state_t ST_WRITE     = 3'd3;
  localparam state_t ST_WAIT_CMPL = 3'd4;
  localparam state_t ST_RESP      = 3'd5;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_SIZE-1:0] tag;
    logic [LINE_BITS-1:0]    data;
  } line_t;

  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0]     line,
    input logic [WORD_SEL_BITS-1:0] word,
    input logic [WORD_BITS-1:0]     wdata,
    input logic [7:0]               wstrb
  );
    logic [LINE_BITS-1:0] merged;
    merged = line;
    for (int b = 0; b < 8; b++) begin
      if (wstrb[b]) begin
        merged[int'(word) * WORD_BITS + b * 8 +: 8] = wdata[b * 8 +: 8];
      end else begin
        merged[int'(word) * WORD_BITS + b * 8 +: 8] = line[int'(word) * WORD_BITS + b * 8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Line storage for the L1 data cache: combinational read port, one write
// port for fills and store merges, and a single-cycle invalidate of every line.
module l1_dcache_array
  import l1_pkg::*;
#(
  parameter int LINE_COUNT = 16,
  parameter int INDEX_SIZE = $clog2(LINE_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_SIZE-1:0] rd_index,
  output line_t                 rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_SIZE-1:0] wr_index,
  input  line_t                 wr_line,
  input  logic                  inval_all
);

  logic [LINE_COUNT-1:0]   valid_r;
  logic [MAX_TAG_SIZE-1:0] tag_r  [LINE_COUNT];
  logic [LINE_BITS-1:0]    data_r [LINE_COUNT];

  // Valid bits are the only state that reset and flush must clear.
  always_ff @(posedge clk) begin
    if (reset || inval_all) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= wr_line.valid;
    end
  end

  // Tag and data payload; meaningless while the matching valid bit is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_line.tag;
      data_r[wr_index] <= wr_line.data;
    end
  end

  // Read port.
  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_r[rd_index];
    rd_line.tag   = tag_r[rd_index];
    rd_line.data  = data_r[rd_index];
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, write-allocate L1 data cache. One request in
// flight; every store pushes its merged full line to the LLC.
module l1_dcache
  import l1_pkg::*;
#(
  parameter int LINE_COUNT     = 16,
  parameter int BYTES_PER_LINE = 64,
  parameter int INDEX_SIZE     = $clog2(LINE_COUNT),
  parameter int TAG_SIZE       = 64 - INDEX_SIZE - 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_addr,
  input  logic         req_we,
  input  logic [63:0]  req_wdata,
  input  logic [7:0]   req_wstrb,
  output logic         resp_valid,
  output logic [63:0]  resp_rdata,
  input  logic         flush,
  output logic [63:0]  S2_R_ADDR,
  output logic         S2_R_ADDR_VALID,
  input  logic [511:0] S2_R_DATA,
  input  logic         S2_R_DATA_VALID,
  output logic         S_W_VALID,
  output logic [63:0]  S_W_ADDR,
  output logic [511:0] S_W_DATA,
  input  logic         S_W_READY,
  input  logic         S_W_COMPLETE
);

  localparam int OFFSET_BITS = $clog2(BYTES_PER_LINE);

  state_t                     state_r, state_next_s;
  logic [63:WORD_LSB]         addr_r;
  logic                       we_r;
  logic [63:0]                wdata_r;
  logic [7:0]                 wstrb_r;
  logic [INDEX_SIZE-1:0]      index_s;
  logic [TAG_SIZE-1:0]        tag_s;
  logic [WORD_SEL_BITS-1:0]   word_s;
  logic [63:0]                line_addr_s;
  logic [63:0]                rd_word_s;
  logic [LINE_BITS-1:0]       merged_s;
  logic                       hit_s, wr_en_s, inval_s;
  line_t                      rd_line_s, wr_line_s;
  logic                       s2_addr_valid_r, s_w_valid_r, resp_valid_r;
  logic [63:0]                s2_addr_r, s_w_addr_r, resp_rdata_r;
  logic [LINE_BITS-1:0]       s_w_data_r;
  logic                       unused_addr_s;

  assign unused_addr_s = ^req_addr[WORD_LSB-1:0];

  assign index_s     = addr_r[INDEX_SIZE+OFFSET_BITS-1:OFFSET_BITS];
  assign tag_s       = addr_r[63 -: TAG_SIZE];
  assign word_s      = addr_r[OFFSET_BITS-1:WORD_LSB];
  assign line_addr_s = {addr_r[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign hit_s       = rd_line_s.valid && (rd_line_s.tag == MAX_TAG_SIZE'(tag_s));
  assign rd_word_s   = rd_line_s.data[int'(word_s) * WORD_BITS +: WORD_BITS];
  assign merged_s    = merge_word(rd_line_s.data, word_s, wdata_r, wstrb_r);
  assign inval_s     = (state_r == ST_IDLE) && flush;

  assign req_ready       = (state_r == ST_IDLE) && !flush;
  assign resp_valid      = resp_valid_r;
  assign resp_rdata      = resp_rdata_r;
  assign S2_R_ADDR       = s2_addr_r;
  assign S2_R_ADDR_VALID = s2_addr_valid_r;
  assign S_W_VALID       = s_w_valid_r;
  assign S_W_ADDR        = s_w_addr_r;
  assign S_W_DATA        = s_w_data_r;

  l1_dcache_array #(
    .LINE_COUNT (LINE_COUNT),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (index_s),
    .rd_line   (rd_line_s),
    .wr_en     (wr_en_s),
    .wr_index  (index_s),
    .wr_line   (wr_line_s),
    .inval_all (inval_s)
  );

  // Array write: a store hit merges into the resident line, a fill installs the LLC line.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_line_s = '0;
    if (state_r == ST_LOOKUP && hit_s && we_r) begin
      wr_en_s        = 1'b1;
      wr_line_s.valid = 1'b1;
      wr_line_s.tag   = MAX_TAG_SIZE'(tag_s);
      wr_line_s.data  = merged_s;
    end else if (state_r == ST_FILL && S2_R_DATA_VALID) begin
      wr_en_s        = 1'b1;
      wr_line_s.valid = 1'b1;
      wr_line_s.tag   = MAX_TAG_SIZE'(tag_s);
      wr_line_s.data  = S2_R_DATA;
    end else begin
      wr_en_s   = 1'b0;
      wr_line_s = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (req_valid) begin
          state_next_s = ST_LOOKUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (!hit_s) begin
          state_next_s = ST_FILL;
        end else if (we_r) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_FILL: begin
        if (S2_R_DATA_VALID) begin
          state_next_s = ST_LOOKUP;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (S_W_READY) begin
          state_next_s = ST_WAIT_CMPL;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_WAIT_CMPL: begin
        if (S_W_COMPLETE) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT_CMPL;
        end
      end
      ST_RESP:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, request latches and registered LLC/core outputs; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      addr_r          <= '0;
      we_r            <= 1'b0;
      wdata_r         <= 64'd0;
      wstrb_r         <= 8'd0;
      s2_addr_valid_r <= 1'b0;
      s2_addr_r       <= 64'd0;
      s_w_valid_r     <= 1'b0;
      s_w_addr_r      <= 64'd0;
      s_w_data_r      <= '0;
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 64'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_IDLE && !flush && req_valid) begin
        addr_r  <= req_addr[63:WORD_LSB];
        we_r    <= req_we;
        wdata_r <= req_wdata;
        wstrb_r <= req_wstrb;
      end
      s2_addr_valid_r <= (state_next_s == ST_FILL);
      if (state_next_s == ST_FILL) begin
        s2_addr_r <= line_addr_s;
      end
      s_w_valid_r <= (state_next_s == ST_WRITE);
      if (state_r == ST_LOOKUP && hit_s && we_r) begin
        s_w_addr_r <= line_addr_s;
        s_w_data_r <= merged_s;
      end
      resp_valid_r <= (state_next_s == ST_RESP);
      resp_rdata_r <= (state_r == ST_LOOKUP && hit_s && !we_r) ? rd_word_s : 64'd0;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: an LLC model serves fills and line writes, and
// scoreboard queues of expected responses, fills and writes are drained by monitors.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_addr = 64'd0;
  logic         req_we = 1'b0;
  logic [63:0]  req_wdata = 64'd0;
  logic [7:0]   req_wstrb = 8'd0;
  logic         resp_valid;
  logic [63:0]  resp_rdata;
  logic         flush = 1'b0;
  logic [63:0]  S2_R_ADDR;
  logic         S2_R_ADDR_VALID;
  logic [511:0] S2_R_DATA = '0;
  logic         S2_R_DATA_VALID = 1'b0;
  logic         S_W_VALID;
  logic [63:0]  S_W_ADDR;
  logic [511:0] S_W_DATA;
  logic         S_W_READY = 1'b0;
  logic         S_W_COMPLETE = 1'b0;

  l1_dcache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .flush(flush),
    .S2_R_ADDR(S2_R_ADDR), .S2_R_ADDR_VALID(S2_R_ADDR_VALID),
    .S2_R_DATA(S2_R_DATA), .S2_R_DATA_VALID(S2_R_DATA_VALID),
    .S_W_VALID(S_W_VALID), .S_W_ADDR(S_W_ADDR), .S_W_DATA(S_W_DATA),
    .S_W_READY(S_W_READY), .S_W_COMPLETE(S_W_COMPLETE)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] rdata; int lat; } resp_exp_t;
  typedef struct { logic [63:0] addr; logic [511:0] data; } wr_exp_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           accept_cyc = 0;
  resp_exp_t    resp_q[$];
  logic [63:0]  fill_q[$];
  wr_exp_t      wr_q[$];
  logic [511:0] mem [logic [63:0]];
  int           s2_stall = 0, sw_stall = 0, s2_wait = 0, sw_wait = 0, cmpl_cnt = 0;
  logic         s2_prev = 1'b0, sw_prev = 1'b0;
  logic [63:0]  s2_prev_addr = 64'd0, sw_prev_addr = 64'd0;
  logic [511:0] sw_prev_data = '0;
  resp_exp_t    r_mon;
  wr_exp_t      w_mon;
  logic [511:0] line1000, line2040, exp_line;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] default_line(input logic [63:0] la);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = {la[31:0], 32'(w)};
    return l;
  endfunction

  function automatic logic [511:0] llc_line(input logic [63:0] la);
    if (mem.exists(la)) return mem[la];
    return default_line(la);
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // LLC read port and fill-address monitor
  always @(negedge clk) begin
    if (S2_R_ADDR_VALID) begin
      if (s2_wait >= s2_stall) begin
        S2_R_DATA_VALID = 1'b1;
        S2_R_DATA = llc_line(S2_R_ADDR);
      end else begin
        S2_R_DATA_VALID = 1'b0;
        s2_wait++;
      end
    end else begin
      S2_R_DATA_VALID = 1'b0;
      s2_wait = 0;
    end
    if (S2_R_ADDR_VALID && !s2_prev) begin
      if (fill_q.size() == 0) flag("s2_unexpected_fill");
      else check("s2_addr", S2_R_ADDR, fill_q.pop_front());
    end else if (S2_R_ADDR_VALID && s2_prev) begin
      check("s2_addr_stable", S2_R_ADDR, s2_prev_addr);
    end
    s2_prev = S2_R_ADDR_VALID;
    s2_prev_addr = S2_R_ADDR;
  end

  // LLC write port: ready after sw_stall cycles, complete one cycle after handshake
  always @(negedge clk) begin
    S_W_COMPLETE = (cmpl_cnt == 1);
    if (cmpl_cnt > 0) cmpl_cnt--;
    if (S_W_VALID && sw_prev) begin
      check("sw_addr_stable", S_W_ADDR, sw_prev_addr);
      check("sw_data_stable", S_W_DATA, sw_prev_data);
    end
    if (S_W_VALID) begin
      if (sw_wait >= sw_stall) begin
        S_W_READY = 1'b1;
        if (wr_q.size() == 0) flag("sw_unexpected_write");
        else begin
          w_mon = wr_q.pop_front();
          check("sw_addr", S_W_ADDR, w_mon.addr);
          check("sw_data", S_W_DATA, w_mon.data);
        end
        mem[S_W_ADDR] = S_W_DATA;
        cmpl_cnt = 2;
      end else begin
        S_W_READY = 1'b0;
        sw_wait++;
      end
    end else begin
      S_W_READY = 1'b0;
      sw_wait = 0;
    end
    sw_prev = S_W_VALID;
    sw_prev_addr = S_W_ADDR;
    sw_prev_data = S_W_DATA;
  end

  // Response monitor: data and accept-to-response latency
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (resp_q.size() == 0) flag("resp_unexpected");
      else begin
        r_mon = resp_q.pop_front();
        check("resp_rdata", resp_rdata, r_mon.rdata);
        check("resp_latency", 512'(cyc - accept_cyc), 512'(r_mon.lat));
      end
    end
  end

  task automatic issue(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                       input logic [7:0] wstrb, input logic [63:0] exp_rdata, input int exp_lat,
                       input logic with_flush);
    int n;
    resp_q.push_back('{rdata: exp_rdata, lat: exp_lat});
    @(negedge clk);
    req_addr = addr; req_we = we; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1; flush = with_flush;
    if (with_flush) begin
      #1;
      check("flush_blocks_ready", req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
    end
    #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      flag("accept_timeout");
      req_valid = 1'b0;
      resp_q.delete();
      return;
    end
    accept_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    n = 0;
    while (resp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (resp_q.size() != 0) begin
      flag("resp_timeout");
      resp_q.delete();
    end
  endtask

  initial begin
    int n;
    line1000 = default_line(64'h1000);
    line1000[1*64 +: 64] = 64'h0000_0000_DEAD_BEEF;
    mem[64'h1000] = line1000;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_s2_valid", S2_R_ADDR_VALID, 1'b0);
    check("rst_s2_addr", S2_R_ADDR, 64'd0);
    check("rst_sw_valid", S_W_VALID, 1'b0);
    check("rst_sw_addr", S_W_ADDR, 64'd0);
    check("rst_sw_data", S_W_DATA, 512'd0);
    reset = 1'b0;

    // Cold load, LLC stalls 3 cycles, then a hit with no fill
    s2_stall = 3;
    fill_q.push_back(64'h1000);
    issue(64'h1008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_DEAD_BEEF, 7, 1'b0);
    s2_stall = 0;
    issue(64'h1008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_DEAD_BEEF, 2, 1'b0);

    // Partial store hit, then read back the merged word
    exp_line = line1000;
    exp_line[2*64 +: 64] = 64'h0000_1000_5566_7788;
    wr_q.push_back('{addr: 64'h1000, data: exp_line});
    issue(64'h1010, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 5, 1'b0);
    issue(64'h1010, 1'b0, 64'd0, 8'd0, 64'h0000_1000_5566_7788, 2, 1'b0);

    // Store miss: fill then write-through
    line2040 = default_line(64'h2040);
    line2040[0 +: 64] = 64'hAABB_CCDD_EEFF_0011;
    fill_q.push_back(64'h2040);
    wr_q.push_back('{addr: 64'h2040, data: line2040});
    issue(64'h2040, 1'b1, 64'hAABB_CCDD_EEFF_0011, 8'hFF, 64'd0, 7, 1'b0);

    // Write slot busy for 5 cycles
    sw_stall = 5;
    line2040[1*64 +: 64] = 64'h0102_0304_0000_0001;
    wr_q.push_back('{addr: 64'h2040, data: line2040});
    issue(64'h2048, 1'b1, 64'h0102_0304_0506_0708, 8'hF0, 64'd0, 10, 1'b0);
    sw_stall = 0;
    issue(64'h2048, 1'b0, 64'd0, 8'd0, 64'h0102_0304_0000_0001, 2, 1'b0);

    // Conflict misses on index 0
    fill_q.push_back(64'h0000);
    issue(64'h0008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_0000_0001, 4, 1'b0);
    fill_q.push_back(64'h0400);
    issue(64'h0408, 1'b0, 64'd0, 8'd0, 64'h0000_0400_0000_0001, 4, 1'b0);
    fill_q.push_back(64'h0000);
    issue(64'h0008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_0000_0001, 4, 1'b0);

    // Resident hit, then flush racing a request: flush wins, request refills
    issue(64'h0008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_0000_0001, 2, 1'b0);
    fill_q.push_back(64'h0000);
    issue(64'h0008, 1'b0, 64'd0, 8'd0, 64'h0000_0000_0000_0001, 4, 1'b1);

    // Reset in the middle of a fill
    s2_stall = 30;
    fill_q.push_back(64'h3040);
    @(negedge clk);
    req_addr = 64'h3048; req_we = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!S2_R_ADDR_VALID && n < 20) begin @(negedge clk); n++; end
    check("fill_started", S2_R_ADDR_VALID, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_s2_valid", S2_R_ADDR_VALID, 1'b0);
    check("midrst_sw_valid", S_W_VALID, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    s2_stall = 0;
    fill_q.push_back(64'h2040);
    issue(64'h2048, 1'b0, 64'd0, 8'd0, 64'h0102_0304_0000_0001, 4, 1'b0);

    repeat (3) @(negedge clk);
    check("resp_q_drained", 512'(resp_q.size()), 512'd0);
    check("fill_q_drained", 512'(fill_q.size()), 512'd0);
    check("wr_q_drained", 512'(wr_q.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-through, write-allocate L1 data cache between the core load/store unit and the last-level cache. Accepts one 64-bit load or store at a time, fills 64-byte lines over the LLC second read port (S2), and pushes every store to the LLC as a full merged 512-bit line over the LLC write port. Holds no dirty state; the LLC owns write-back to AXI.

## Interface
- LINE_COUNT, 16, number of L1 lines (power of two).
- BYTES_PER_LINE, 64, fixed to match the 512-bit LLC line.
- INDEX_SIZE, $clog2(LINE_COUNT), index width.
- TAG_SIZE, 64-INDEX_SIZE-6, tag width.

Ports:
- clk  in  1  clock; one clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE with flush low.
- req_addr  in  64  byte address; bits [2:0] ignored.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  64  store data.
- req_wstrb  in  8  byte enables; lane b = bits [8b+7:8b].
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  64  load data; 0 for stores.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- S2_R_ADDR  out  64  line-aligned fill address.
- S2_R_ADDR_VALID  out  1  fill request.
- S2_R_DATA  in  512  LLC line data.
- S2_R_DATA_VALID  in  1  LLC hit on S2_R_ADDR (combinational in LLC).
- S_W_VALID  out  1  line write request.
- S_W_ADDR  out  64  line-aligned write address.
- S_W_DATA  out  512  merged line.
- S_W_READY  in  1  LLC write slot free.
- S_W_COMPLETE  in  1  LLC write committed pulse.

## Operation
- Address split: offset [5:0], word = addr[5:3], index = addr[INDEX_SIZE+5:6], tag = top TAG_SIZE bits. Word w occupies line bits [64w+63:64w].
- States: IDLE, LOOKUP, FILL, WRITE, WAIT_CMPL, RESP.
- IDLE: if flush, clear all valid bits (req_ready=0 that cycle, stay IDLE). Else if req_valid, latch addr/we/wdata/wstrb -> LOOKUP.
- LOOKUP: hit = valid[index] && tag match. Miss -> FILL. Load hit -> RESP with resp_rdata = word. Store hit -> merge wstrb bytes into stored line, write merged line into array and into write buffer -> WRITE.
- FILL: S2_R_ADDR_VALID=1, S2_R_ADDR={tag,index,6'b0} held stable. Cycle S2_R_DATA_VALID=1: install data, tag, valid=1 -> LOOKUP (guaranteed hit).
- WRITE: S_W_VALID=1, S_W_ADDR line-aligned, S_W_DATA = buffer, held stable. Transfer when S_W_VALID && S_W_READY -> WAIT_CMPL; deassert S_W_VALID next cycle.
- WAIT_CMPL: wait S_W_COMPLETE=1 -> RESP.
- RESP: resp_valid=1 one cycle -> IDLE.
- S2_R_ADDR_VALID low outside FILL; S_W_VALID low outside WRITE.
- Only one request in flight; no hit-under-miss.

## Timing
- Reset: state IDLE, all valid bits 0, req_ready=1, resp_valid=0, resp_rdata=0, S2_R_ADDR_VALID=0, S_W_VALID=0, S2_R_ADDR=0, S_W_ADDR=0, S_W_DATA=0.
- Load hit: accept cycle T, resp_valid at T+2.
- Load miss, LLC hit: FILL T+2, LOOKUP T+3, resp T+4; each extra LLC miss cycle adds one.
- Store hit, S_W_READY high, S_W_COMPLETE one cycle after handshake: resp at T+5.
- Reset mid-operation: returns to IDLE next edge, drops S2/S_W valids, no resp_valid, all lines invalid; an LLC write already handed off is not retracted.
- flush and req_valid same cycle: flush wins; request stays pending.
- S_W_COMPLETE outside WAIT_CMPL ignored.
- wstrb=0 store: still performs full write-through of unchanged line.

## Structure
- Package l1_pkg: state enum, line typedef {valid, tag, data[511:0]}, offset/word constants.
- Sub-module l1_dcache_array: LINE_COUNT-entry storage, one read port, one write port (install/merge), single-cycle invalidate-all.
- Top holds FSM, request latches, byte-merge, write buffer.

## Test plan
- Load 0x1008 cold, LLC returns line with word1=0xDEADBEEF after 3 stall cycles -> one S2 request at 0x1000, resp_rdata=0xDEADBEEF, repeat load hits at T+2 with no S2 activity.
- Store 0x1010 wdata=0x1122334455667788 wstrb=0x0F on resident line -> S_W_DATA word2 low 4 bytes 0x55667788, upper bytes unchanged, S_W_ADDR=0x1000; subsequent load returns merged word.
- Store miss to 0x2040 -> FILL at 0x2040, then S_W with merged line, resp after S_W_COMPLETE.
- S_W_READY held low 5 cycles -> S_W_VALID/ADDR/DATA stable, no resp until COMPLETE.
- Conflict: load 0x0000 then 0x0400 (same index, LINE_COUNT=16) -> second misses and refills; reload 0x0000 misses again.
- flush while resident then load; reset asserted during FILL -> next request refills, no stray resp_valid.
